// File: rtl/key_note_scheduler.sv
// PS/2 set-2 scan-code decoder feeding a last-note-priority key stack that drives
// the tone generator's period word, note gate and retrigger pulse.
//
// state    | meaning
// S_IDLE   | waiting for a fresh sequence; plain bytes are make codes
// S_BRK    | 0xF0 seen; next byte is a break code
// S_EXT    | 0xE0 seen; extended make, ignored
// S_EXTBRK | 0xE0 0xF0 seen; extended break, ignored
module key_note_scheduler #(
    parameter int DEPTH   = 4,
    parameter int VALUE_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         code,
    input  logic               code_valid,
    input  logic [1:0]         octave,
    output logic [VALUE_W-1:0] value,
    output logic               note_on,
    output logic               retrig,
    output logic [3:0]         held_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} state_t;

    state_t             state, state_n;
    logic               make_ev, brk_ev;
    logic               key_ok;
    logic [2:0]         key_idx;
    logic [2:0]         stk   [DEPTH];
    logic [2:0]         stk_n [DEPTH];
    logic [3:0]         cnt, cnt_n;
    logic               hit;
    int                 hit_pos;
    logic [2:0]         top_idx;
    logic               note_n;
    logic [VALUE_W-1:0] value_n;

    function automatic logic [VALUE_W-1:0] base_of(input logic [2:0] idx);
        case (idx)
            3'd0:    base_of = VALUE_W'(373);
            3'd1:    base_of = VALUE_W'(333);
            3'd2:    base_of = VALUE_W'(296);
            3'd3:    base_of = VALUE_W'(280);
            3'd4:    base_of = VALUE_W'(249);
            3'd5:    base_of = VALUE_W'(222);
            3'd6:    base_of = VALUE_W'(198);
            default: base_of = VALUE_W'(187);
        endcase
    endfunction

    // Keys are stored as a 3-bit map index rather than the raw scan code.
    always_comb begin
        key_ok  = 1'b1;
        key_idx = 3'd0;
        case (code)
            8'h1C:   key_idx = 3'd0;
            8'h1B:   key_idx = 3'd1;
            8'h23:   key_idx = 3'd2;
            8'h2B:   key_idx = 3'd3;
            8'h34:   key_idx = 3'd4;
            8'h33:   key_idx = 3'd5;
            8'h3B:   key_idx = 3'd6;
            8'h42:   key_idx = 3'd7;
            default: key_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        if (code_valid) begin
            case (state)
                S_IDLE: begin
                    if (code == 8'hF0)      state_n = S_BRK;
                    else if (code == 8'hE0) state_n = S_EXT;
                    else                    make_ev = key_ok;
                end
                S_BRK: begin
                    brk_ev  = key_ok;
                    state_n = S_IDLE;
                end
                S_EXT:   state_n = (code == 8'hF0) ? S_EXTBRK : S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Index 0 is the oldest entry; the newest held key sits at cnt-1.
    always_comb begin
        hit     = 1'b0;
        hit_pos = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && i < int'(cnt) && stk[i] == key_idx) begin
                hit     = 1'b1;
                hit_pos = i;
            end
        end

        stk_n = stk;
        cnt_n = cnt;
        if (make_ev && !hit) begin
            if (int'(cnt) < DEPTH) begin
                for (int i = 0; i < DEPTH; i++)
                    if (i == int'(cnt)) stk_n[i] = key_idx;
                cnt_n = cnt + 4'd1;
            end else begin
                for (int i = 0; i < DEPTH - 1; i++)
                    stk_n[i] = stk[i+1];
                stk_n[DEPTH-1] = key_idx;
            end
        end else if (brk_ev && hit) begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (i >= hit_pos) stk_n[i] = stk[i+1];
            cnt_n = cnt - 4'd1;
        end
    end

    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < DEPTH; i++)
            if (i == int'(cnt) - 1) top_idx = stk[i];
        note_n  = (cnt != 4'd0);
        value_n = base_of(top_idx) >> octave;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            for (int i = 0; i < DEPTH; i++) stk[i] <= 3'd0;
            value   <= '0;
            note_on <= 1'b0;
            retrig  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            stk     <= stk_n;
            note_on <= note_n;
            // Value freezes while no key is held so the generator sees no glitch.
            if (note_n) value <= value_n;
            retrig  <= note_n && (!note_on || value_n != value);
        end
    end

    assign held_cnt = cnt;

endmodule

// File: doc/key_note_scheduler.md
Name: key_note_scheduler

Overview:
- Turns the keyboard scan-code byte stream into the period control word and gating signals for the sine-table tone generator.
- Decodes PS/2 set-2 make, break and extended sequences.
- Tracks up to DEPTH held keys with last-note priority.
- Outputs the selected note's period word with an optional octave shift, a note_on gate, and a retrigger pulse that restarts the generator's period counter whenever the period changes.

Parameters:
- DEPTH, 4: number of simultaneously held keys tracked (2..8).
- VALUE_W, 10: width of the period word; must match the tone generator's value input.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: asynchronous, active-low reset. Asserted when 0; all state clears immediately.
- code, input, 8: received scan-code byte.
- code_valid, input, 1: one-cycle strobe marking code valid.
- octave, input, 2: octave shift 0..3; the period word is shifted right by octave.
- value, output, VALUE_W: period word to the tone generator.
- note_on, output, 1: high while at least one mapped key is held.
- retrig, output, 1: one-cycle pulse; the tone generator resets its address/count on it.
- held_cnt, output, 4: number of keys currently in the stack.

Behaviour:
- Reset (rst=0): decoder to S_IDLE; stack empty; value=0, note_on=0, retrig=0, held_cnt=0.
- Key map (code -> base period, = 100e6/(f*1024) rounded):
  - 0x1C -> 373
  - 0x1B -> 333
  - 0x23 -> 296
  - 0x2B -> 280
  - 0x34 -> 249
  - 0x33 -> 222
  - 0x3B -> 198
  - 0x42 -> 187
  - Any other code is unmapped.
- Decoder FSM; transitions occur only on code_valid cycles:
  - S_IDLE: 0xF0 -> S_BRK; 0xE0 -> S_EXT; other -> make event, stay in S_IDLE.
  - S_BRK: any byte -> break event for that byte, go to S_IDLE.
  - S_EXT: 0xF0 -> S_EXTBRK; other -> go to S_IDLE with no event (extended keys are ignored).
  - S_EXTBRK: any byte -> go to S_IDLE with no event.
- Make event for a mapped key:
  - Key already in stack (typematic repeat): no change.
  - Stack not full: push on top; held_cnt+1.
  - Stack full: discard the oldest entry, shift the others down, push the new key on top; held_cnt unchanged.
- Break event for a mapped key:
  - Key in stack: remove it and compact entries above it downward; held_cnt-1.
  - Key not in stack: ignore.
- Unmapped make/break bytes: ignored; the FSM still advances.
- Output timing: value, note_on and retrig are registered and reflect stack state one cycle after the stack update. Total latency from code_valid of the final byte of a sequence to the output is 2 cycles.
- Output computation:
  - note_on = (held_cnt != 0).
  - When note_on is high, value = base(top) >> octave, computed in VALUE_W bits.
  - When the stack is empty, value holds its last value (no glitch to 0).
- retrig is high for exactly one cycle when either:
  - note_on rises, or
  - note_on is high and the new value differs from the current value. This includes an octave change and a top-key change caused by a break that uncovers a different key.
- retrig is never asserted when note_on falls.
- A held-key change that leaves the top entry and octave unchanged does not pulse retrig.
- An octave change while note_on is low has no visible effect until the next note.
- code_valid on back-to-back cycles must be handled; each byte is processed in order.
- Reset mid-sequence (for example, after 0xF0) returns the FSM to S_IDLE; the next byte is treated as a fresh sequence.

Test Plan:
1. Reset, then make 0x1C with octave=0 -> 2 cycles later value=373, note_on=1, retrig high for 1 cycle, held_cnt=1.
2. Hold 0x1C, make 0x34, then send F0 34 -> value 249 with retrig, then back to 373 with retrig; held_cnt 2 then 1. Then send F0 1C -> note_on=0, value stays 373, no retrig.
3. Make 1C, 1B, 23, 2B, 34 (DEPTH=4) -> held_cnt=4, value=249. Then F0 1C -> ignored (1C was evicted); held_cnt stays 4.
4. Hold 0x33 with octave=0 (value 222), change octave to 2 -> value=55, one retrig pulse. Repeated make 0x33 -> no retrig.
5. Send E0 1C, then E0 F0 1C, then 0x15 (unmapped) -> no change on any output; FSM returns to S_IDLE after each sequence.
6. Send F0, pulse rst low, then send 0x1C -> make event: note_on=1, value=373.
